// File: rtl/manchester_decode.sv
// Iterative Manchester decoder: recovers a DATA_W payload from a 2*DATA_W codeword, PAIRS_PER_CYCLE pairs per clock.
// Optional MANCH_ERR_POS_EN adds err_pos, the index of the lowest invalid symbol pair.
module manchester_decode #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned PAIRS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   code_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     data_out,
    output logic                  err
`ifdef MANCH_ERR_POS_EN
    ,
    output logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] err_pos
`endif
);

    localparam int unsigned CODE_W = 2 * DATA_W;
    localparam int unsigned STEPS  = DATA_W / PAIRS_PER_CYCLE;
    localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned POS_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SHIFT  = 2 * PAIRS_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if ((DATA_W % PAIRS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("PAIRS_PER_CYCLE must divide DATA_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE} state_t;

    state_t                     state;
    logic [CODE_W-1:0]          shreg;
    logic [DATA_W-1:0]          acc;
    logic                       err_acc;
    logic [CNT_W-1:0]           cnt;
    logic [PAIRS_PER_CYCLE-1:0] bits_c;
    logic [PAIRS_PER_CYCLE-1:0] bad_c;
    logic [POS_W-1:0]           base_c;

    // Decode the lowest PAIRS_PER_CYCLE pairs; equal symbol halves are invalid.
    always_comb begin
        bits_c = '0;
        bad_c  = '0;
        for (int j = 0; j < int'(PAIRS_PER_CYCLE); j++) begin
            bits_c[j] = (shreg[2*j +: 2] == 2'b10);
            bad_c[j]  = shreg[2*j+1] ~^ shreg[2*j];
        end
    end

    assign base_c = POS_W'(cnt) * POS_W'(PAIRS_PER_CYCLE);

`ifdef MANCH_ERR_POS_EN
    logic [POS_W-1:0] first_idx_c;
    logic [POS_W-1:0] pos_acc;

    // Scan downward so the lowest invalid pair in this cycle wins.
    always_comb begin
        first_idx_c = '0;
        for (int j = int'(PAIRS_PER_CYCLE) - 1; j >= 0; j--) begin
            if (bad_c[j]) first_idx_c = POS_W'(j);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            acc      <= '0;
            err_acc  <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            err      <= 1'b0;
`ifdef MANCH_ERR_POS_EN
            pos_acc  <= '0;
            err_pos  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= code_in;
                        acc     <= '0;
                        err_acc <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
`ifdef MANCH_ERR_POS_EN
                        pos_acc <= '0;
`endif
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    acc[base_c +: PAIRS_PER_CYCLE] <= bits_c;
                    shreg   <= shreg >> SHIFT;
                    err_acc <= err_acc | (|bad_c);
`ifdef MANCH_ERR_POS_EN
                    // Only the first cycle that sees an invalid pair records its position.
                    if (!err_acc && (|bad_c)) pos_acc <= base_c + first_idx_c;
`endif
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    data_out <= acc;
                    err      <= err_acc;
`ifdef MANCH_ERR_POS_EN
                    err_pos  <= pos_acc;
`endif
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/manchester_decode.md
Name: manchester_decode

Overview:
- Iterative Manchester decoder: the receive-side counterpart of the 64-to-128-bit encoder `top` (start/done handshake).
- Takes a 128-bit codeword, recovers the 64-bit payload and flags invalid symbol pairs.
- Processes PAIRS_PER_CYCLE symbol pairs per clock, so area and latency trade off under one parameter.
- Sits after the encoded link/storage path, opposite `top`.

Parameters:
- DATA_W, 64, payload width; the codeword is 2*DATA_W bits.
- PAIRS_PER_CYCLE, 4, symbol pairs decoded per DECODE cycle; must divide DATA_W (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- code_in  input  2*DATA_W  codeword; sampled on the accepting edge only.
- busy  output  1  high in DECODE and DONE.
- done  output  1  one-cycle pulse; data_out/err valid.
- data_out  output  DATA_W  decoded payload, held until the next accepted start.
- err  output  1  at least one invalid pair in the last codeword; held like data_out.

Behaviour:
- Symbol map: data bit i comes from code_in[2i+1:2i].
  - 2'b10 -> 1.
  - 2'b01 -> 0.
  - 2'b00 / 2'b11 are invalid: bit decodes to 0 and err is set.
- Reset (async assert, any state including mid-DECODE): state=IDLE, busy=0, done=0, data_out=0, err=0; internal shift register and counter cleared. On release, decoding restarts only on a new start.
- FSM states:
  - IDLE: start=1 -> latch code_in into the shift register, clear the accumulator and error flag, counter=0, go to DECODE.
  - DECODE: each cycle consumes the lowest PAIRS_PER_CYCLE pairs (LSB first), writes the decoded bits into the accumulator, shifts the register right by 2*PAIRS_PER_CYCLE, and ORs any invalid-pair flags into the sticky error. After DATA_W/PAIRS_PER_CYCLE cycles (counter reaches last value) go to DONE.
  - DONE: one cycle. done=1; data_out/err registered from the accumulator/sticky flag on entry. Then IDLE.
- Latency:
  - start sampled at edge k -> done high during the cycle after edge k+DATA_W/PAIRS_PER_CYCLE+1 (17 edges for the defaults).
  - Back-to-back: next start accepted in the cycle after done (IDLE).
- start while busy=1 (DECODE or DONE) is ignored and not queued; code_in changes while busy have no effect.
- data_out/err are updated only in DONE and otherwise hold their last value, including across ignored starts.
- Counter width is clog2(DATA_W/PAIRS_PER_CYCLE), minimum 1; no wrap beyond the terminal count.
- PAIRS_PER_CYCLE=DATA_W: a single DECODE cycle, latency 2.

Optional Feature:
- Macro: MANCH_ERR_POS_EN.
- Defined:
  - Adds port err_pos, output, clog2(DATA_W) bits: index i of the lowest-numbered invalid pair.
  - Updated in DONE together with err; 0 when err=0; reset value 0.
  - If several invalid pairs fall in one DECODE cycle, the lowest index wins. A later cycle never overwrites an earlier recorded position.
- Undefined: port absent; no position logic; err behaviour unchanged.

Test Plan:
- Reset/idle: assert reset mid-run with start held low -> busy=0, done=0, data_out=0, err=0. After release, no done pulse for 40 cycles.
- All-zero payload: code_in=128'h5555...5555, start pulsed -> done exactly 17 cycles after start is sampled, data_out=64'h0, err=0. Repeat with 128'hAAAA...AAAA -> data_out=64'hFFFFFFFFFFFFFFFF, err=0.
- Round-trip with encoder values: codewords of 64'h123456789ABCDEF0, then 64'hFEDCBA9876543210 (1->10, 0->01), issued back-to-back at the first legal cycle -> data_out matches each payload, err=0, two done pulses 18 cycles apart.
- Errors: all-0x55 codeword with bits[1:0]=2'b11 -> data_out=0, err=1, err_pos=0 (feature on). Bits[127:126]=2'b00 plus bits[9:8]=2'b11 -> err=1, err_pos=4.
- Ignored start: pulse start with a different code_in during DECODE -> first result unchanged, only one done pulse, busy stays high throughout.
- Reset mid-DECODE: assert reset 5 cycles after start -> immediate IDLE, outputs cleared, no done pulse. A fresh start then decodes correctly with 17-cycle latency.
